// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one iterative signed divider among REQUESTERS clients.
// Define DIVIDER_ARBITER_TIMEOUT_EN to bound the BUSY wait by TIMEOUT cycles.
module divider_arbiter #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned TIMEOUT    = WIDTH + 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [REQUESTERS-1:0]       request,
    input  logic [REQUESTERS*WIDTH-1:0] dividend,
    input  logic [REQUESTERS*WIDTH-1:0] divisor,
    output logic [REQUESTERS-1:0]       grant,
    output logic [REQUESTERS-1:0]       done,
    output logic [WIDTH-1:0]            quotient,
    output logic [WIDTH-1:0]            remainder,
    output logic                        fault,
    output logic                        divStart,
    output logic [WIDTH-1:0]            divDividend,
    output logic [WIDTH-1:0]            divDivisor,
    input  logic [WIDTH-1:0]            divQuotient,
    input  logic [WIDTH-1:0]            divRemainder,
    input  logic                        divReady
);

    localparam int unsigned PtrW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [2:0] {StIdle, StIssue, StSettle, StBusy, StRespond} state_e;

    state_e                  state_q, state_d;
    logic [PtrW-1:0]         pointer_q, pointer_d;
    logic [PtrW-1:0]         gnt_idx_q, gnt_idx_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [REQUESTERS-1:0]   done_q, done_d;
    logic [WIDTH-1:0]        quotient_q, quotient_d;
    logic [WIDTH-1:0]        remainder_q, remainder_d;
    logic                    fault_q, fault_d;
    logic                    start_q, start_d;
    logic [WIDTH-1:0]        dvd_q, dvd_d;
    logic [WIDTH-1:0]        dvs_q, dvs_d;

    logic                    found;
    logic [PtrW-1:0]         sel_idx;
    logic [PtrW:0]           sum;
    logic [WIDTH-1:0]        sel_dvd;
    logic [WIDTH-1:0]        sel_dvs;

`ifdef DIVIDER_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    // First requester at or after the pointer, wrapping modulo REQUESTERS.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sum     = '0;
        for (int i = 0; i < int'(REQUESTERS); i++) begin
            sum = {1'b0, pointer_q} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(REQUESTERS)) begin
                sum = sum - (PtrW+1)'(REQUESTERS);
            end
            if (!found && request[sum[PtrW-1:0]]) begin
                found   = 1'b1;
                sel_idx = sum[PtrW-1:0];
            end
        end
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < int'(REQUESTERS); i++) begin
            if (sel_idx == PtrW'(i)) begin
                sel_dvd = dividend[i*WIDTH +: WIDTH];
                sel_dvs = divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pointer_d   = pointer_q;
        gnt_idx_d   = gnt_idx_q;
        grant_d     = grant_q;
        done_d      = '0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        fault_d     = fault_q;
        start_d     = 1'b0;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gnt_idx_d        = sel_idx;
                    dvd_d            = sel_dvd;
                    dvs_d            = sel_dvs;
                    if (sel_dvs == '0) begin
                        state_d     = StRespond;
                        done_d      = grant_d;
                        fault_d     = 1'b1;
                        quotient_d  = '0;
                        remainder_d = '0;
                    end else begin
                        state_d = StIssue;
                        start_d = 1'b1;
                    end
                end
            end
            StIssue: state_d = StSettle;
            StSettle: begin
                if (divReady) begin
                    state_d     = StRespond;
                    done_d      = grant_q;
                    fault_d     = 1'b0;
                    quotient_d  = divQuotient;
                    remainder_d = divRemainder;
                end else begin
                    state_d = StBusy;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                if (divReady) begin
                    state_d     = StRespond;
                    done_d      = grant_q;
                    fault_d     = 1'b0;
                    quotient_d  = divQuotient;
                    remainder_d = divRemainder;
                end
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d     = StRespond;
                    done_d      = grant_q;
                    fault_d     = 1'b1;
                    quotient_d  = '0;
                    remainder_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StRespond: begin
                grant_d   = '0;
                pointer_d = (gnt_idx_q == PtrW'(REQUESTERS - 1)) ? '0 : gnt_idx_q + 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pointer_q   <= '0;
            gnt_idx_q   <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            fault_q     <= 1'b0;
            start_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pointer_q   <= pointer_d;
            gnt_idx_q   <= gnt_idx_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            fault_q     <= fault_d;
            start_q     <= start_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign fault       = fault_q;
    assign divStart    = start_q;
    assign divDividend = dvd_q;
    assign divDivisor  = dvs_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural iterative-divider model.
module tb_divider_arbiter;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int TO = W + 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [R-1:0]   request;
    logic [R*W-1:0] dividend;
    logic [R*W-1:0] divisor;
    logic [R-1:0]   grant;
    logic [R-1:0]   done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           fault;
    logic           divStart;
    logic [W-1:0]   divDividend;
    logic [W-1:0]   divDivisor;
    logic [W-1:0]   m_q = '0;
    logic [W-1:0]   m_r = '0;
    logic           m_rdy = 1'b0;
    logic           hang = 1'b0;
    int             m_cnt = 0;

    int checks = 0;
    int errors = 0;
    int cyc, nstart, scyc;

    logic [R-1:0] rr_done [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] rr_q    [5] = '{4'h3, 4'hD, 4'h2, 4'hB, 4'h4};
    logic [W-1:0] rr_r    [5] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h0};

    divider_arbiter #(.WIDTH(W), .REQUESTERS(R), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (request),
        .dividend    (dividend),
        .divisor     (divisor),
        .grant       (grant),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .fault       (fault),
        .divStart    (divStart),
        .divDividend (divDividend),
        .divDivisor  (divDivisor),
        .divQuotient (m_q),
        .divRemainder(m_r),
        .divReady    (m_rdy)
    );

    always #5 clock = ~clock;

    // Divisor 1 takes the fast path; anything else is ready WIDTH cycles after start.
    always @(posedge clock) begin
        if (divStart) begin
            m_q <= $signed(divDividend) / $signed(divDivisor);
            m_r <= $signed(divDividend) % $signed(divDivisor);
            if (divDivisor == 4'd1) begin
                m_rdy <= 1'b1;
            end else begin
                m_rdy <= 1'b0;
                m_cnt <= W - 1;
            end
        end else if (!m_rdy && !hang) begin
            if (m_cnt == 0) m_rdy <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        dividend[c*W +: W] = a;
        divisor[c*W +: W]  = b;
    endtask

    // Returns the cycle of the first done (or -1 if the bound expires).
    task automatic wait_done(input int max, output int c, output int ns, output int sc);
        bit seen;
        c = 0; ns = 0; sc = -1; seen = 1'b0;
        while (!seen && c < max) begin
            @(posedge clock);
            c++;
            @(negedge clock);
            if (divStart) begin
                ns++;
                if (sc < 0) sc = c;
            end
            if (done != '0) seen = 1'b1;
        end
        if (!seen) c = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        request  = '0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clock);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_fault", fault, 0);
        check("rst_start", divStart, 0);
        check("rst_dvd", divDividend, 0);
        check("rst_dvs", divDivisor, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Round robin: all four hold, client 0 re-requests while client 3 waits.
        set_op(0, 4'd7, 4'd2);
        set_op(1, 4'h9, 4'd2);
        set_op(2, 4'd6, 4'd3);
        set_op(3, 4'd5, 4'hF);
        request = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_done(40, cyc, nstart, scyc);
            check("rr_done", done, rr_done[k]);
            check("rr_grant", grant, rr_done[k]);
            check("rr_quot", quotient, rr_q[k]);
            check("rr_rem", remainder, rr_r[k]);
            check("rr_fault", fault, 0);
            request = request & ~done;
            if (k == 2) begin
                set_op(0, 4'd4, 4'd1);
                request[0] = 1'b1;
            end
        end
        @(negedge clock);
        check("rr_pulse_clear", done, 0);

        // Long path 7/2 on client 0.
        set_op(0, 4'd7, 4'd2);
        request = 4'b0001;
        wait_done(20, cyc, nstart, scyc);
        check("long_cycle", cyc, 7);
        check("long_start_cycle", scyc, 1);
        check("long_start_count", nstart, 1);
        check("long_done", done, 4'b0001);
        check("long_quot", quotient, 4'd3);
        check("long_rem", remainder, 4'd1);
        check("long_fault", fault, 0);
        request = '0;
        @(negedge clock);
        check("long_done_drop", done, 0);
        check("long_quot_hold", quotient, 4'd3);

        // Divide by zero on client 2.
        set_op(2, 4'd5, 4'd0);
        request = 4'b0100;
        wait_done(20, cyc, nstart, scyc);
        check("dz_cycle", cyc, 1);
        check("dz_start_count", nstart, 0);
        check("dz_done", done, 4'b0100);
        check("dz_fault", fault, 1);
        check("dz_quot", quotient, 0);
        check("dz_rem", remainder, 0);
        request = '0;
        @(negedge clock);

        // Fast path -6/1 on client 1.
        set_op(1, 4'hA, 4'd1);
        request = 4'b0010;
        wait_done(20, cyc, nstart, scyc);
        check("fast_cycle", cyc, 3);
        check("fast_done", done, 4'b0010);
        check("fast_quot", quotient, 4'hA);
        check("fast_rem", remainder, 4'd0);
        check("fast_fault", fault, 0);
        request = '0;
        @(negedge clock);

        // Reset during BUSY.
        set_op(0, 4'd7, 4'd3);
        request = 4'b0001;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
        end
        request = '0;
        reset_n = 1'b0;
        #1;
        check("abort_grant", grant, 0);
        check("abort_done", done, 0);
        check("abort_start", divStart, 0);
        check("abort_quot", quotient, 0);
        check("abort_fault", fault, 0);
        check("abort_dvs", divDivisor, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
        end
        reset_n = 1'b1;
        @(negedge clock);
        request = 4'b0001;
        wait_done(20, cyc, nstart, scyc);
        check("after_cycle", cyc, 7);
        check("after_done", done, 4'b0001);
        check("after_quot", quotient, 4'd2);
        check("after_rem", remainder, 4'd1);
        request = '0;
        @(negedge clock);

`ifdef DIVIDER_ARBITER_TIMEOUT_EN
        // Divider never ready: BUSY lasts TIMEOUT cycles, then pointer moves past client 1.
        hang = 1'b1;
        set_op(1, 4'd7, 4'd2);
        request = 4'b0010;
        wait_done(40, cyc, nstart, scyc);
        check("to_cycle", cyc, 3 + TO);
        check("to_done", done, 4'b0010);
        check("to_fault", fault, 1);
        check("to_quot", quotient, 0);
        request = '0;
        @(negedge clock);
        hang = 1'b0;
        set_op(2, 4'd6, 4'd3);
        request = 4'b0110;
        wait_done(40, cyc, nstart, scyc);
        check("to_next_done", done, 4'b0100);
        check("to_next_quot", quotient, 4'd2);
        request = '0;
        @(negedge clock);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one iterative signed `Divider` instance among `REQUESTERS` clients. It latches the granted requester's operands, issues a one-cycle start to the divider, and tracks the divider's registered ready through both the fast-path and the O(WIDTH) completion cases. It returns the quotient and remainder to the granted requester with a one-cycle done pulse. It sits between the arithmetic clients and the shared divider in the arithmetic subsystem.

## Interface
- `WIDTH`, 4, operand/result width; must match the divider.
- `REQUESTERS`, 4, number of clients (≥2).
- `TIMEOUT`, WIDTH+4, BUSY-cycle limit; used only with the macro.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `request`  in  REQUESTERS  level request per client.
- `dividend`  in  REQUESTERS*WIDTH  client i operand at `[i*WIDTH +: WIDTH]`, signed.
- `divisor`  in  REQUESTERS*WIDTH  same packing, signed.
- `grant`  out  REQUESTERS  one-hot; the client being served.
- `done`  out  REQUESTERS  one-hot, one-cycle completion pulse.
- `quotient`  out  WIDTH  result, valid while `done` is nonzero.
- `remainder`  out  WIDTH  result, valid while `done` is nonzero.
- `fault`  out  1  divide-by-zero or timeout, valid while `done` is nonzero.
- `divStart`  out  1  start strobe to the divider.
- `divDividend`, `divDivisor`  out  WIDTH  operands to the divider.
- `divQuotient`, `divRemainder`  in  WIDTH  divider results.
- `divReady`  in  1  divider ready; this is a registered output of the divider.

## Operation
- **States:** IDLE, ISSUE, SETTLE, BUSY, RESPOND. The state is binary encoded.
- **IDLE:** If any `request` is high, select the first set bit at or after `pointer` (modular). Then:
  - set `grant`;
  - latch that client's operands into `divDividend`/`divDivisor`;
  - go to ISSUE.
  - Exception: if the latched divisor is 0, skip the divider and go straight to RESPOND with `fault`=1 and `quotient`=`remainder`=0.
- **ISSUE:** `divStart`=1 for exactly this cycle. Go to SETTLE.
- **SETTLE:** `divReady` now reflects the start. If it is 1 (divider fast path), capture the results and go to RESPOND. Otherwise go to BUSY.
- **BUSY:** Wait for `divReady`=1, then capture `divQuotient`/`divRemainder` with `fault`=0 and go to RESPOND.
- **RESPOND:** `done`=`grant` for one cycle. Set `pointer` to granted index+1 mod REQUESTERS. Clear `grant` on exit. Go to IDLE.
- **Divider inputs outside the sampling window:** `divReady` is never sampled outside SETTLE/BUSY. Stale or X values of `divReady` are ignored. The divider's own fault output is not used.
- **Held requests:** A request still high in IDLE after its own `done` is treated as a new operation. Clients must drop `request` on `done` if they want only one result.
- **Requests in other states:** Requests that arrive in non-IDLE states wait; no request is lost or reordered except by the round-robin rule.
- **Pointer:** `pointer` is $clog2(REQUESTERS) bits and wraps from REQUESTERS-1 to 0.
- **Result sign:** Results pass through unmodified; the sign conventions are those of the divider.

## Timing
- **Reset values:** `grant`=0, `done`=0, `quotient`=0, `remainder`=0, `fault`=0, `divStart`=0, `divDividend`=0, `divDivisor`=0; state IDLE; `pointer`=0.
- **Reset mid-operation:** Asynchronous reset aborts immediately and no `done` is produced. The divider's in-flight result is ignored. The next ISSUE restarts the divider, because start overrides any operation in progress.
- **Latency** (request sampled in IDLE at cycle 0):
  - divisor 0: `done` at cycle 1;
  - divider fast path: `done` at cycle 3;
  - long division: `done` at cycle 3+WIDTH.
- **Throughput:** IDLE occupies one cycle between operations, so back-to-back grants are spaced latency+1 cycles.
- **Output timing:** All outputs are registered. `quotient`/`remainder`/`fault` hold their value after `done` until the next RESPOND.

## Configuration
- **With `DIVIDER_ARBITER_TIMEOUT_EN` defined:** A counter runs in BUSY. If `TIMEOUT` cycles elapse without `divReady`, the block goes to RESPOND with `fault`=1 and `quotient`=`remainder`=0, and the pointer advances normally.
- **Without `DIVIDER_ARBITER_TIMEOUT_EN`:** BUSY waits indefinitely, the counter is absent, and `TIMEOUT` is unused.

## Test plan
- **Long path, single client:** WIDTH=4, client 0 requests 7÷2. Required: `divStart` at cycle 1, `done`=0001 at cycle 7, `quotient`=3, `remainder`=1, `fault`=0.
- **Divide by zero:** client 2 requests 5÷0. Required: `done`=0100 at cycle 1, `fault`=1, `quotient`=`remainder`=0, and `divStart` is never asserted.
- **Fast path:** client 1 requests -6÷1. Required: `done`=0010 at cycle 3, `quotient`=-6, `remainder`=0.
- **Round-robin ordering:** all four clients hold `request` with distinct operands, each dropping on its own `done`. Required: grants served in order 0,1,2,3, each result matching its operands. A subsequent request from client 0 while client 3 is pending is served after client 3.
- **Reset mid-operation:** assert `reset_n`=0 during BUSY. Required: outputs at reset values immediately and no `done`. A new request of 7÷3 afterwards returns `quotient`=2, `remainder`=1.
- **Timeout (macro defined):** hold `divReady`=0 through BUSY. Required: `done` with `fault`=1 after `TIMEOUT` BUSY cycles, and the pointer advances.
